// File: rtl/microcode_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : microcode_sequencer_if
// Brief    : Bus bundle between a controller and the microcode sequencer:
//            run/stall/opcode inputs, the microcode load port, and the
//            control-word and status outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface microcode_sequencer_if #(
    parameter int CTRL_W      = 32,
    parameter int OPCODE_W    = 8,
    parameter int NUM_OPS     = 16,
    parameter int FETCH_STEPS = 3,
    parameter int EXEC_STEPS  = 8
) ();
    localparam int DEPTH   = FETCH_STEPS + NUM_OPS * EXEC_STEPS;
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int ENTRY_W = CTRL_W + 2;

    logic                run;
    logic                stall;
    logic [OPCODE_W-1:0] opcode_in;
    logic                load_en;
    logic [ADDR_W-1:0]   load_addr;
    logic [ENTRY_W-1:0]  load_data;
    logic [CTRL_W-1:0]   ctrl_out;
    logic                instr_done;
    logic                halted;
    logic                illegal_op;
    logic                load_err;

    modport master (
        output run, stall, opcode_in, load_en, load_addr, load_data,
        input  ctrl_out, instr_done, halted, illegal_op, load_err
    );

    modport slave (
        input  run, stall, opcode_in, load_en, load_addr, load_data,
        output ctrl_out, instr_done, halted, illegal_op, load_err
    );
endinterface
`default_nettype wire

// File: rtl/microcode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : microcode_sequencer
// Brief    : Writable microcode store with step counter, opcode latch and
//            IDLE/FETCH/EXEC/HALT sequencer. Emits one control word per
//            non-stalled cycle; traps illegal opcodes and HALT entries.
// Revision : 1.0 - initial release
// ============================================================================
module microcode_sequencer #(
    parameter int CTRL_W      = 32,
    parameter int OPCODE_W    = 8,
    parameter int NUM_OPS     = 16,
    parameter int FETCH_STEPS = 3,
    parameter int EXEC_STEPS  = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    microcode_sequencer_if.slave      bus
);
    localparam int DEPTH     = FETCH_STEPS + NUM_OPS * EXEC_STEPS;
    localparam int ADDR_W    = $clog2(DEPTH);
    localparam int ENTRY_W   = CTRL_W + 2;
    localparam int MAX_STEPS = (FETCH_STEPS > EXEC_STEPS) ? FETCH_STEPS : EXEC_STEPS;
    localparam int STEP_W    = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

    localparam logic [STEP_W-1:0]   c_fetch_last = STEP_W'(FETCH_STEPS - 1);
    localparam logic [STEP_W-1:0]   c_exec_last  = STEP_W'(EXEC_STEPS - 1);
    localparam logic [ADDR_W-1:0]   c_exec_base  = ADDR_W'(FETCH_STEPS);
    localparam logic [ADDR_W-1:0]   c_exec_size  = ADDR_W'(EXEC_STEPS);
    localparam logic [ADDR_W:0]     c_depth      = (ADDR_W + 1)'(DEPTH);
    localparam logic [OPCODE_W:0]   c_num_ops    = (OPCODE_W + 1)'(NUM_OPS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    // Microcode store: no reset so that contents survive rst.
    logic [ENTRY_W-1:0] store_mem [DEPTH];

    state_t              state_q,      state_d;
    logic [STEP_W-1:0]   step_q,       step_d;
    logic [OPCODE_W-1:0] opcode_q,     opcode_d;
    logic                illegal_op_q, illegal_op_d;
    logic                halted_q,     halted_d;
    logic                load_err_q,   load_err_d;

    logic [ADDR_W-1:0]   w_addr;
    logic [ENTRY_W-1:0]  w_entry;
    logic                w_end;
    logic                w_halt;
    logic                w_active;
    logic                w_op_illegal;
    logic                w_load_ok;
    logic                w_instr_done;

    // Store address: fetch slots sit at the bottom, each opcode owns an
    // EXEC_STEPS-long execute window above them.
    always_comb begin
        w_addr = ADDR_W'(step_q);
        if (state_q == S_EXEC) begin
            w_addr = c_exec_base + ADDR_W'(opcode_q) * c_exec_size + ADDR_W'(step_q);
        end
    end

    assign w_entry      = store_mem[w_addr];
    assign w_end        = w_entry[CTRL_W];
    assign w_halt       = w_entry[CTRL_W+1];
    assign w_active     = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign w_op_illegal = ({1'b0, bus.opcode_in} >= c_num_ops);
    assign w_load_ok    = ((state_q == S_IDLE) || (state_q == S_HALT)) &&
                          ({1'b0, bus.load_addr} < c_depth);

    // Next-state, step, opcode latch and trap logic; stall freezes everything.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        opcode_d     = opcode_q;
        illegal_op_d = illegal_op_q;
        w_instr_done = 1'b0;
        if (!bus.stall) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.run) begin
                        state_d = S_FETCH;
                        step_d  = '0;
                    end
                end
                S_FETCH: begin
                    if (step_q == c_fetch_last) begin
                        step_d = '0;
                        if (w_op_illegal) begin
                            state_d      = S_HALT;
                            illegal_op_d = 1'b1;
                        end else begin
                            state_d  = S_EXEC;
                            opcode_d = bus.opcode_in;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (w_halt) begin
                        state_d      = S_HALT;
                        step_d       = '0;
                        w_instr_done = 1'b1;
                    end else if (w_end || (step_q == c_exec_last)) begin
                        state_d      = S_FETCH;
                        step_d       = '0;
                        w_instr_done = 1'b1;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_IDLE;
                    step_d  = '0;
                end
            endcase
        end
        halted_d   = (state_d == S_HALT);
        load_err_d = bus.load_en && !w_load_ok;
    end

    // Sequencer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            step_q       <= '0;
            opcode_q     <= '0;
            illegal_op_q <= 1'b0;
            halted_q     <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            opcode_q     <= opcode_d;
            illegal_op_q <= illegal_op_d;
            halted_q     <= halted_d;
            load_err_q   <= load_err_d;
        end
    end

    // Runtime microcode write, accepted only while the sequencer is parked.
    always_ff @(posedge clk) begin
        if (!rst && bus.load_en && w_load_ok) begin
            store_mem[bus.load_addr] <= bus.load_data;
        end
    end

    // Stalled or parked cycles drive an all-zero word so nothing is replayed.
    assign bus.ctrl_out   = (w_active && !bus.stall) ? w_entry[CTRL_W-1:0] : '0;
    assign bus.instr_done = w_instr_done;
    assign bus.halted     = halted_q;
    assign bus.illegal_op = illegal_op_q;
    assign bus.load_err   = load_err_q;
endmodule
`default_nettype wire

// File: doc/microcode_sequencer.md
# microcode_sequencer

Parametrised microcode control unit: a writable microcode store plus the step counter, opcode latch and sequencing FSM that drive it. Every instruction runs a shared fetch/decode micro-routine and then its own execute micro-routine. The block emits one control word per cycle to the datapath (register, ALU, tri-state, MAR, memory and PC enables). It adds stall, per-word end and halt flags, illegal-opcode trapping and runtime microcode loading.

## Interface
Parameters:
- CTRL_W, 32: control-word width driven to the datapath.
- OPCODE_W, 8: opcode width taken from the instruction register.
- NUM_OPS, 16: number of implemented opcodes, 0..NUM_OPS-1.
- FETCH_STEPS, 3: length of the shared fetch/decode routine, ≥1.
- EXEC_STEPS, 8: execute slots per opcode. Must be a power of 2.
- Derived:
  - DEPTH = FETCH_STEPS + NUM_OPS*EXEC_STEPS
  - ADDR_W = clog2(DEPTH)
  - ENTRY_W = CTRL_W+2

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  leave IDLE and start fetching.
- stall  in  1  freeze sequencing this cycle.
- opcode_in  in  OPCODE_W  opcode from the instruction register.
- load_en  in  1  write one microcode entry.
- load_addr  in  ADDR_W  store address to write.
- load_data  in  ENTRY_W  entry to write:
  - [CTRL_W-1:0] control word.
  - [CTRL_W] END.
  - [CTRL_W+1] HALT.
- ctrl_out  out  CTRL_W  current control word.
- instr_done  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  high in HALT state.
- illegal_op  out  1  sticky illegal-opcode flag.
- load_err  out  1  one-cycle pulse when a load is rejected.

## Operation
- States and transitions:
  - IDLE → FETCH on run.
  - FETCH → EXEC after the last fetch step.
  - EXEC → FETCH on end of instruction.
  - EXEC → HALT on a HALT entry.
  - FETCH → HALT on an illegal opcode.
  - HALT exits only via rst.
- Store address:
  - FETCH: step.
  - EXEC: FETCH_STEPS + opcode_q*EXEC_STEPS + step.
- ctrl_out:
  - store[addr][CTRL_W-1:0] in FETCH or EXEC when stall=0.
  - 0 in IDLE, in HALT, and whenever stall=1, so no side effect is replayed.
  - Combinational from state, step, opcode_q and stall.
- step counter:
  - Advances by 1 per non-stalled cycle.
  - Clears to 0 on every state change.
- Opcode latch:
  - On the non-stalled cycle with step==FETCH_STEPS-1, opcode_q <= opcode_in.
  - If opcode_in ≥ NUM_OPS: go to HALT instead of EXEC and set illegal_op. opcode_q is not updated.
- End of instruction, on a non-stalled EXEC cycle:
  - Occurs when the entry's END bit is set, or when step==EXEC_STEPS-1 (forced end; the last slot always terminates).
  - instr_done=1 that cycle; next state FETCH, step 0.
- HALT entry, on a non-stalled EXEC cycle:
  - The word is output that cycle and instr_done=1.
  - Next state HALT. HALT takes priority over END.
- END and HALT bits in fetch entries are ignored.
- Microcode loading:
  - load_en writes store[load_addr] <= load_data at the edge, only in IDLE or HALT with load_addr < DEPTH.
  - Otherwise the write is dropped and load_err=1 for that cycle.
  - In IDLE, load_en and run may be asserted together: the write occurs and the state moves to FETCH.
- Reset (rst=1 at an edge):
  - State IDLE, step 0, opcode_q 0.
  - illegal_op 0, instr_done 0, load_err 0, halted 0, ctrl_out 0.
  - Store contents are preserved.
  - rst overrides run, stall and load_en, including mid-instruction; no write occurs that cycle.

## Timing
- One micro-step per non-stalled cycle.
- Instruction latency = FETCH_STEPS + executed steps; with defaults, 3 + n cycles plus stall cycles.
- run sampled in IDLE: first fetch word appears the next cycle.
- Fetch resumes the cycle after instr_done with no bubble.
- stall=1: state, step and opcode_q hold; instr_done and the opcode latch are suppressed.
- halted and illegal_op are registered; both rise the cycle after the trapping edge.
- instr_done is combinational in the completing cycle.
- load_err is registered; it is high the cycle after the rejected request.
- A write is readable on ctrl_out from the cycle after the edge.

## Test plan
- Load fetch words A0/A1/A2 at 0..2 and opcode 2 entries at 19, 20, with END on 20; opcode_in=2, pulse run.
  - ctrl_out = A0, A1, A2, w19, w20.
  - instr_done on the w20 cycle, then A0 again.
- Assert stall for 2 cycles during the w19 cycle.
  - ctrl_out=0 for 2 cycles.
  - w19 then appears unrepeated, followed by w20; total latency +2.
- Execute an opcode with no END bit in any slot.
  - Exactly 8 exec words, forced instr_done on slot 7, then fetch.
- Present opcode_in=16 at the last fetch step.
  - halted=1 and illegal_op=1 next cycle, ctrl_out=0.
  - A load now succeeds; only rst clears the flags.
- load_en during EXEC, and load_addr=131 in IDLE.
  - load_err pulses once for each; store unchanged; sequencing unaffected.
- Assert rst mid-EXEC at step 1.
  - IDLE, ctrl_out=0, all flags 0.
  - run replays the same microcode from fetch step 0.
